// File: rtl/signed_serial_multiplier_9_cla.sv
// Sequential signed two's-complement multiplier, one multiplier bit per clock
// (shift-and-add). Partial products are accumulated through a carry-lookahead
// adder built from 4-bit CLA groups. The final multiplier bit carries weight
// -2^(width-1), so that iteration subtracts instead of adding.
//
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   rst_n  - synchronous active-low reset
//   en     - start strobe, honoured in IDLE and DONE only
//   A      - signed multiplicand (width bits)
//   B      - signed multiplier (width bits)
//   valid  - high while S holds a completed product
//   S      - signed product A*B (2*width bits)
module signed_serial_multiplier_9_cla #(
  parameter int unsigned width = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [width-1:0]     A,
  input  logic [width-1:0]     B,
  output logic                 valid,
  output logic [2*width-1:0]   S
);

  localparam int unsigned PW     = 2 * width;
  localparam int unsigned NGrp   = (PW + 3) / 4;
  localparam int unsigned PadW   = NGrp * 4;
  localparam int unsigned CntW   = (width > 1) ? $clog2(width) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(width - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q;
  logic [width-1:0]    a_q;
  logic [width-1:0]    b_q;
  logic [PW-1:0]       acc_q;
  logic [CntW-1:0]     cnt_q;
  logic [PW-1:0]       s_q;
  logic                valid_q;

  // Partial-product selection for the current iteration
  logic [PW-1:0]       ext_a;
  logic [PW-1:0]       shifted_a;
  logic [PW-1:0]       addend;
  logic                cin;
  logic                last_iter;

  assign last_iter = (cnt_q == LastCnt);
  assign ext_a     = {{width{a_q[width-1]}}, a_q};
  assign shifted_a = ext_a << cnt_q;

  always_comb begin
    addend = '0;
    cin    = 1'b0;
    if (b_q[cnt_q]) begin
      if (last_iter) begin
        // Sign bit of B has negative weight: add the two's complement
        addend = ~shifted_a;
        cin    = 1'b1;
      end else begin
        addend = shifted_a;
      end
    end
  end

  // Carry-lookahead adder: 4-bit groups with full in-group lookahead, group
  // generate/propagate chained between groups. Operands padded to a
  // multiple of 4 bits with zeros.
  logic [PadW-1:0]     op_a;
  logic [PadW-1:0]     op_b;
  logic [PadW-1:0]     gen;
  logic [PadW-1:0]     prop;
  logic [PadW:0]       carry;
  logic [NGrp-1:0]     grp_g;
  logic [NGrp-1:0]     grp_p;
  logic [PadW-1:0]     sum_full;
  logic [PW-1:0]       sum;

  assign op_a = PadW'(acc_q);
  assign op_b = PadW'(addend);
  assign gen  = op_a & op_b;
  assign prop = op_a ^ op_b;

  always_comb begin
    carry    = '0;
    grp_g    = '0;
    grp_p    = '0;
    carry[0] = cin;
    for (int k = 0; k < int'(NGrp); k++) begin
      carry[4*k+1] = gen[4*k] | (prop[4*k] & carry[4*k]);
      carry[4*k+2] = gen[4*k+1] | (prop[4*k+1] & gen[4*k])
                   | (prop[4*k+1] & prop[4*k] & carry[4*k]);
      carry[4*k+3] = gen[4*k+2] | (prop[4*k+2] & gen[4*k+1])
                   | (prop[4*k+2] & prop[4*k+1] & gen[4*k])
                   | (prop[4*k+2] & prop[4*k+1] & prop[4*k] & carry[4*k]);
      grp_g[k]     = gen[4*k+3] | (prop[4*k+3] & gen[4*k+2])
                   | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                   | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
      grp_p[k]     = &prop[4*k +: 4];
      carry[4*k+4] = grp_g[k] | (grp_p[k] & carry[4*k]);
    end
  end

  assign sum_full = prop ^ carry[PadW-1:0];
  assign sum      = sum_full[PW-1:0];

  // Result is taken mod 2^(2*width); upper padding and carry-out are dropped
  logic unused_cla;
  if (PadW > PW) begin : g_pad
    assign unused_cla = ^{sum_full[PadW-1:PW], carry[PadW]};
  end else begin : g_nopad
    assign unused_cla = carry[PadW];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (en) begin
            a_q     <= A;
            b_q     <= B;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          acc_q <= sum;
          cnt_q <= cnt_q + CntW'(1);
          if (last_iter) begin
            s_q     <= sum;
            valid_q <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign valid = valid_q;
  assign S     = s_q;

endmodule

// File: tb/tb_signed_serial_multiplier_9_cla.sv
module tb_signed_serial_multiplier_9_cla;

  localparam int W  = 9;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          valid;
  logic [PW-1:0] s;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  signed_serial_multiplier_9_cla dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .A     (a),
    .B     (b),
    .valid (valid),
    .S     (s)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] prod(input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, p;
    logic [31:0] pv;
    sx = int'($signed(x));
    sy = int'($signed(y));
    p  = sx * sy;
    pv = p;
    return pv[PW-1:0];
  endfunction

  // Behavioural model: a start in idle/done arms a W-cycle countdown, after
  // which the exact product appears with valid.
  logic          m_valid = 1'b0;
  logic [PW-1:0] m_s = '0;
  logic [PW-1:0] m_prod = '0;
  logic          m_busy = 1'b0;
  logic          m_idle = 1'b1;
  int            m_left = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_s     <= '0;
      m_busy  <= 1'b0;
      m_idle  <= 1'b1;
      m_left  <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_s     <= m_prod;
      end
    end else if (en) begin
      m_busy  <= 1'b1;
      m_left  <= W;
      m_valid <= 1'b0;
      m_idle  <= 1'b0;
      m_prod  <= prod(a, b);
    end
  end

  // Cycle-by-cycle compare; S is only defined while valid or after reset
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (valid !== m_valid) begin
        fails++;
        $display("FAIL model_valid t=%0t: got %b expected %b", $time, valid, m_valid);
      end
      if (m_valid || m_idle) begin
        tests++;
        if (s !== m_s) begin
          fails++;
          $display("FAIL model_S t=%0t: got %h expected %h", $time, s, m_s);
        end
      end
    end
  end

  task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Start an operation at a negedge; optionally pulse en mid-busy with other
  // operands. Returns once valid is seen (or the bound expires).
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [PW-1:0] exp, input string name, input bit poke);
    int lat;
    a  = x;
    b  = y;
    en = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    lat = 0;
    while (!valid && lat < 30) begin
      if (poke && lat == 4) en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      lat++;
    end
    check({name, "_latency"}, PW'(lat), PW'(W));
    check(name, s, exp);
  endtask

  initial begin
    // 1: reset held 4 cycles
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("reset_valid", PW'(valid), '0);
    check("reset_S", s, '0);
    repeat (3) @(negedge clk);
    check("idle_valid", PW'(valid), '0);

    // 2-4: literal expectations
    run_op(9'd255, 9'd255, 18'h0FE01, "p255x255", 1'b0);
    repeat (3) @(negedge clk);
    check("hold_S", s, 18'h0FE01);
    check("hold_valid", PW'(valid), PW'(1));
    run_op(9'h100, 9'h100, 18'h10000, "m256xm256", 1'b0);
    run_op(9'h100, 9'd255, 18'h30100, "m256x255", 1'b0);
    run_op(9'h1FF, 9'd1, 18'h3FFFF, "m1x1", 1'b0);
    run_op(9'd0, 9'h1DB, 18'h00000, "0xm37", 1'b0);
    run_op(9'd1, 9'h100, 18'h3FF00, "1xm256", 1'b0);

    // 5: back-to-back from DONE, and en pulsed mid-busy is ignored
    run_op(9'd17, 9'h1F6, 18'h3FF56, "17xm10_b2b", 1'b0);
    run_op(9'd100, 9'd3, 18'h0012C, "100x3_poke", 1'b1);

    // 6: reset during busy aborts the operation
    a = 9'd77; b = 9'd5; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    check("abort_valid", PW'(valid), '0);
    check("abort_S", s, '0);
    begin
      int seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (valid) seen++;
      end
      check("abort_no_result", PW'(seen), '0);
    end
    run_op(9'h1FF, 9'h1FF, 18'h00001, "m1xm1_after_abort", 1'b0);

    for (int i = 0; i < 50; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom);
      y = W'($urandom);
      run_op(x, y, prod(x, y), "random", 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
